busca_instrucao: RTL and testbench

BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

---
 rtl/busca_instrucao.sv | 118 +++++++++++
 tb/tb_busca_instrucao.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: requests one word at a time from instruction
// memory, holds it in ir until downstream consumes it, decodes the constant
// field for the extender and flags a sticky error when memory stalls too long.
module busca_instrucao #(
    parameter logic [15:0] PC_RESET   = 16'h0000,
    parameter int          MAX_ESPERA = 15
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] mem_end,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [15:0] mem_dado,
    input  logic        avancar,
    input  logic        desvio,
    input  logic [15:0] alvo,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic        valido,
    output logic [1:0]  controle,
    output logic [10:0] constante,
    output logic [2:0]  reg_c,
    output logic        erro_mem
);

    localparam int CW = $clog2(MAX_ESPERA + 1);
    localparam logic [CW-1:0] LIMITE  = CW'(MAX_ESPERA);
    localparam logic [CW-1:0] LIMITE1 = CW'(MAX_ESPERA - 1);

    typedef enum logic {BUSCA, PRONTO} estado_t;

    estado_t        estado;
    estado_t        estado_prox;
    logic [15:0]    pc_busca;
    logic [CW-1:0]  espera;
    logic           aceita;

    // A fetch completes only when memory answers and no branch overrides it.
    assign aceita = (estado == BUSCA) && mem_ack && !desvio;

    // Request is suppressed while reset is held so nothing is issued early.
    assign mem_rd  = reset && (estado == BUSCA);
    assign mem_end = pc_busca;
    assign valido  = (estado == PRONTO);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= BUSCA;
        else        estado <= estado_prox;
    end

    // Next-state logic: a branch always restarts fetching.
    always_comb begin
        estado_prox = estado;
        if (desvio) begin
            estado_prox = BUSCA;
        end else begin
            case (estado)
                BUSCA:   if (mem_ack) estado_prox = PRONTO;
                PRONTO:  if (avancar) estado_prox = BUSCA;
                default: estado_prox = BUSCA;
            endcase
        end
    end

    // Fetch pointer, instruction register and its address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_busca <= PC_RESET;
            pc       <= PC_RESET;
            ir       <= 16'h0000;
        end else if (desvio) begin
            pc_busca <= alvo;
        end else if (aceita) begin
            ir       <= mem_dado;
            pc       <= pc_busca;
            pc_busca <= pc_busca + 16'd1;
        end
    end

    // Wait counter saturates at the limit; the error flag stays set until reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            espera   <= '0;
            erro_mem <= 1'b0;
        end else if (desvio || aceita) begin
            espera <= '0;
        end else if (estado == BUSCA && espera != LIMITE) begin
            espera <= espera + 1'b1;
            if (espera == LIMITE1) erro_mem <= 1'b1;
        end
    end

    // Field decode for the extender, driven purely from ir.
    always_comb begin
        controle  = 2'b11;
        constante = ir[10:0];
        reg_c     = ir[13:11];
        case (ir[15:14])
            2'b11: begin
                controle  = 2'b00;
                constante = ir[10:0];
                reg_c     = ir[13:11];
            end
            2'b10: begin
                controle  = ir[13] ? 2'b10 : 2'b01;
                constante = {3'b000, ir[7:0]};
                reg_c     = ir[12:10];
            end
            default: begin
                controle  = 2'b11;
                constante = ir[10:0];
                reg_c     = ir[13:11];
            end
        endcase
    end

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: a cycle driver with a behavioural fetch model
// pushes expected instructions to a scoreboard; a monitor pops them when valido rises.
module tb_busca_instrucao;

    localparam logic [15:0] PC_RESET   = 16'h0000;
    localparam int          MAX_ESPERA = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] mem_end;
    logic        mem_rd;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_dado = 16'h0000;
    logic        avancar = 1'b0;
    logic        desvio = 1'b0;
    logic [15:0] alvo = 16'h0000;
    logic [15:0] pc;
    logic [15:0] ir;
    logic        valido;
    logic [1:0]  controle;
    logic [10:0] constante;
    logic [2:0]  reg_c;
    logic        erro_mem;

    busca_instrucao #(.PC_RESET(PC_RESET), .MAX_ESPERA(MAX_ESPERA)) dut (
        .clock(clock), .reset(reset), .mem_end(mem_end), .mem_rd(mem_rd),
        .mem_ack(mem_ack), .mem_dado(mem_dado), .avancar(avancar),
        .desvio(desvio), .alvo(alvo), .pc(pc), .ir(ir), .valido(valido),
        .controle(controle), .constante(constante), .reg_c(reg_c),
        .erro_mem(erro_mem)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ir;
        logic [1:0]  ctl;
        logic [10:0] k;
        logic [2:0]  rc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Behavioural model of the fetch unit
    bit          m_fetching;
    logic [15:0] m_pcf;
    int          m_wait;
    bit          m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t expect_of(input logic [15:0] a, input logic [15:0] w);
        exp_t e;
        e.pc = a;
        e.ir = w;
        if (w[15:14] == 2'b11) begin
            e.ctl = 2'b00; e.k = w[10:0]; e.rc = w[13:11];
        end else if (w[15:14] == 2'b10) begin
            e.ctl = w[13] ? 2'b10 : 2'b01; e.k = {3'b000, w[7:0]}; e.rc = w[12:10];
        end else begin
            e.ctl = 2'b11; e.k = w[10:0]; e.rc = w[13:11];
        end
        return e;
    endfunction

    task automatic model_reset();
        m_fetching = 1'b1;
        m_pcf      = PC_RESET;
        m_wait     = 0;
        m_err      = 1'b0;
        sb.delete();
    endtask

    // One clock cycle: check control outputs, drive inputs, advance model.
    task automatic cycle(input bit ack, input logic [15:0] dado, input bit av,
                         input bit dv, input logic [15:0] tgt);
        @(negedge clock);
        chk("mem_rd", {31'b0, mem_rd}, {31'b0, m_fetching});
        if (m_fetching) chk("mem_end", {16'b0, mem_end}, {16'b0, m_pcf});
        chk("valido", {31'b0, valido}, {31'b0, !m_fetching});
        chk("erro_mem", {31'b0, erro_mem}, {31'b0, m_err});
        mem_ack = ack; mem_dado = dado; avancar = av; desvio = dv; alvo = tgt;
        @(posedge clock);
        if (dv) begin
            m_fetching = 1'b1; m_pcf = tgt; m_wait = 0;
        end else if (m_fetching) begin
            if (ack) begin
                sb.push_back(expect_of(m_pcf, dado));
                m_pcf = m_pcf + 16'd1; m_fetching = 1'b0; m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait >= MAX_ESPERA) m_err = 1'b1;
            end
        end else if (av) begin
            m_fetching = 1'b1;
        end
    endtask

    // Monitor: pop on each new valid instruction, then require it to stay stable.
    exp_t held;
    bit   prev_v = 1'b0;
    always @(negedge clock) begin
        if (!reset) begin
            prev_v = 1'b0;
        end else begin
            if (valido && !prev_v) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    held = sb.pop_front();
                end
            end
            if (valido) begin
                chk("pc", {16'b0, pc}, {16'b0, held.pc});
                chk("ir", {16'b0, ir}, {16'b0, held.ir});
                chk("controle", {30'b0, controle}, {30'b0, held.ctl});
                chk("constante", {21'b0, constante}, {21'b0, held.k});
                chk("reg_c", {29'b0, reg_c}, {29'b0, held.rc});
            end
            prev_v = valido;
        end
    end

    initial begin
        model_reset();
        #2;
        chk("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("rst_valido", {31'b0, valido}, 32'd0);
        chk("rst_pc", {16'b0, pc}, {16'b0, PC_RESET});
        chk("rst_ir", {16'b0, ir}, 32'd0);
        chk("rst_erro", {31'b0, erro_mem}, 32'd0);
        #21 reset = 1'b1;

        // Ack after two waits with a loadlit word
        cycle(0, 16'h0000, 0, 0, 16'h0);
        cycle(0, 16'h0000, 0, 0, 16'h0);
        cycle(1, 16'hC7FF, 0, 0, 16'h0);
        #2;
        chk("c7ff_valido", {31'b0, valido}, 32'd1);
        chk("c7ff_pc", {16'b0, pc}, 32'h0000);
        chk("c7ff_ctl", {30'b0, controle}, 32'd0);
        chk("c7ff_k", {21'b0, constante}, 32'h7FF);
        chk("c7ff_rc", {29'b0, reg_c}, 32'd0);

        // Hold for five cycles, then consume
        for (int i = 0; i < 5; i++) cycle(0, 16'hFFFF, 0, 0, 16'h0);
        cycle(0, 16'h0000, 1, 0, 16'h0);
        #2;
        chk("next_end", {16'b0, mem_end}, 32'h0001);
        chk("next_rd", {31'b0, mem_rd}, 32'd1);

        cycle(1, 16'hA4AB, 0, 0, 16'h0);
        #2;
        chk("lch_ctl", {30'b0, controle}, 32'h2);
        chk("lch_k", {21'b0, constante}, 32'h0AB);
        chk("lch_rc", {29'b0, reg_c}, 32'h1);
        cycle(0, 16'h0000, 1, 0, 16'h0);
        cycle(1, 16'h84AB, 0, 0, 16'h0);
        #2;
        chk("lcl_ctl", {30'b0, controle}, 32'h1);
        cycle(0, 16'h0000, 1, 0, 16'h0);

        // Branch in the same cycle as an ack discards the data
        cycle(1, 16'h1234, 0, 1, 16'h0040);
        #2;
        chk("br_end", {16'b0, mem_end}, 32'h0040);
        chk("br_valido", {31'b0, valido}, 32'd0);
        chk("br_rd", {31'b0, mem_rd}, 32'd1);

        // Fetch pointer wraps from FFFF to 0000
        cycle(0, 16'h0000, 0, 1, 16'hFFFF);
        cycle(1, 16'h1357, 0, 0, 16'h0);
        #2;
        chk("wrap_pc", {16'b0, pc}, 32'hFFFF);
        cycle(0, 16'h0000, 1, 0, 16'h0);
        #2;
        chk("wrap_end", {16'b0, mem_end}, 32'h0000);

        // Timeout raises a sticky error
        for (int i = 0; i < MAX_ESPERA; i++) cycle(0, 16'h0000, 0, 0, 16'h0);
        #2;
        chk("timeout_erro", {31'b0, erro_mem}, 32'd1);
        cycle(1, 16'h2468, 0, 0, 16'h0);
        cycle(0, 16'h0000, 1, 0, 16'h0);
        #2;
        chk("sticky_erro", {31'b0, erro_mem}, 32'd1);

        // Random traffic
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 1), 16'($urandom), $urandom_range(0, 1),
                  ($urandom_range(0, 15) == 0), 16'($urandom));

        // Reset asserted mid-fetch, with a stray ack while reset is held
        cycle(0, 16'h0000, 1, 0, 16'h0);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_rd", {31'b0, mem_rd}, 32'd0);
        chk("mid_rst_valido", {31'b0, valido}, 32'd0);
        chk("mid_rst_pc", {16'b0, pc}, {16'b0, PC_RESET});
        chk("mid_rst_ir", {16'b0, ir}, 32'd0);
        chk("mid_rst_erro", {31'b0, erro_mem}, 32'd0);
        model_reset();
        @(negedge clock);
        mem_ack = 1'b1; mem_dado = 16'hBEEF; avancar = 1'b0; desvio = 1'b0;
        @(posedge clock);
        #2;
        chk("rst_ack_rd", {31'b0, mem_rd}, 32'd0);
        chk("rst_ack_valido", {31'b0, valido}, 32'd0);
        @(negedge clock);
        mem_ack = 1'b0;
        #2 reset = 1'b1;

        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 1), 16'($urandom), $urandom_range(0, 1),
                  ($urandom_range(0, 15) == 0), 16'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
